// File: rtl/axi4l_pkg.sv
// Shared types for the AXI4-Lite register controller.
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  // ST_ prefix keeps the state names clear of the BRESP/RRESP port names.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_BRESP,
    ST_RRESP
  } ctrl_state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } grant_t;

endpackage

// File: rtl/axi4l_reg_ctrl.sv
// AXI4-Lite slave front end for the single-ported config register file.
// AW/W/AR requests land in one-deep holding slots; a round-robin FSM runs
// one register access at a time and turns a missing ack into SLVERR.
module axi4l_reg_ctrl
  import axi4l_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [3:0]              AWCACHE,
  input  logic [2:0]              AWPROT,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [3:0]              ARCACHE,
  input  logic [2:0]              ARPROT,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic                    reg_req,
  output logic                    reg_wr,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_wstrb,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  input  logic                    reg_ack,
  input  logic                    reg_err
);

  localparam int SW = DATA_WIDTH / 8;
  // Keep the counter at least one bit wide when the timeout is disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  ctrl_state_t state, state_nxt;
  grant_t      last_grant, last_grant_nxt;

  logic                  aw_full, w_full, ar_full;
  logic                  aw_full_nxt, w_full_nxt, ar_full_nxt;
  logic                  awready_q, wready_q, arready_q;
  logic                  aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [SW-1:0]         w_strb;

  logic [CW-1:0]         tmo_cnt;
  logic                  tmo_hit, done, wr_done, rd_done;
  logic                  wr_pend, rd_pend;
  resp_t                 acc_resp;
  resp_t                 bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Cache/prot sideband carries nothing this block acts on.
  logic unused_sideband;
  assign unused_sideband = ^{AWCACHE, AWPROT, ARCACHE, ARPROT};

  assign aw_hs = AWVALID && awready_q;
  assign w_hs  = WVALID  && wready_q;
  assign ar_hs = ARVALID && arready_q;

  assign wr_pend = aw_full && w_full;
  assign rd_pend = ar_full;

  // The ack in the TIMEOUT-th cycle still wins because acc_resp looks at
  // reg_ack, not at tmo_hit.
  assign tmo_hit  = (TIMEOUT > 0) && (state == ST_ACCESS) &&
                    (tmo_cnt == CW'(TIMEOUT - 1));
  assign done     = (state == ST_ACCESS) && (reg_ack || tmo_hit);
  assign wr_done  = done && (last_grant == WRITE);
  assign rd_done  = done && (last_grant == READ);
  assign acc_resp = (reg_ack && !reg_err) ? OKAY : SLVERR;

  // Slots free on the completion edge so READY returns while the response
  // is still waiting for its handshake.
  assign aw_full_nxt = wr_done ? 1'b0 : (aw_full || aw_hs);
  assign w_full_nxt  = wr_done ? 1'b0 : (w_full  || w_hs);
  assign ar_full_nxt = rd_done ? 1'b0 : (ar_full || ar_hs);

  // Holding slots and registered READYs (low through reset).
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      ar_full   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      aw_addr   <= '0;
      ar_addr   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
    end else begin
      aw_full   <= aw_full_nxt;
      w_full    <= w_full_nxt;
      ar_full   <= ar_full_nxt;
      awready_q <= !aw_full_nxt;
      wready_q  <= !w_full_nxt;
      arready_q <= !ar_full_nxt;
      if (aw_hs) aw_addr <= AWADDR;
      if (ar_hs) ar_addr <= ARADDR;
      if (w_hs) begin
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
    end
  end

  // State, grant history and access-cycle counter.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      last_grant <= READ;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      tmo_cnt    <= (state == ST_ACCESS) ? tmo_cnt + CW'(1) : '0;
    end
  end

  // Next state; the grant is chosen in IDLE and held in last_grant.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    unique case (state)
      ST_IDLE: begin
        if (wr_pend && (!rd_pend || last_grant == READ)) begin
          state_nxt      = ST_ACCESS;
          last_grant_nxt = WRITE;
        end else if (rd_pend) begin
          state_nxt      = ST_ACCESS;
          last_grant_nxt = READ;
        end
      end
      ST_ACCESS: begin
        if (done) state_nxt = (last_grant == WRITE) ? ST_BRESP : ST_RRESP;
      end
      ST_BRESP: begin
        if (BREADY) state_nxt = ST_IDLE;
      end
      ST_RRESP: begin
        if (RREADY) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Response payload captured on completion, held until the handshake.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bresp_q <= OKAY;
      rresp_q <= OKAY;
      rdata_q <= '0;
    end else begin
      if (wr_done) bresp_q <= acc_resp;
      if (rd_done) begin
        rresp_q <= acc_resp;
        rdata_q <= (acc_resp == OKAY) ? reg_rdata : '0;
      end
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign ARREADY = arready_q;
  assign BVALID  = (state == ST_BRESP);
  assign RVALID  = (state == ST_RRESP);
  assign BRESP   = bresp_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  assign reg_req   = (state == ST_ACCESS);
  assign reg_wr    = reg_req && (last_grant == WRITE);
  assign reg_addr  = !reg_req ? '0 : (reg_wr ? aw_addr : ar_addr);
  assign reg_wdata = reg_wr ? w_data : '0;
  assign reg_wstrb = reg_wr ? w_strb : '0;

endmodule

// File: tb/tb_axi4l_reg_ctrl.sv
// Bench for axi4l_reg_ctrl: hand sequences for latency/arbitration/reset,
// a vector table, and random traffic against a word-level memory model.
module tb_axi4l_reg_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] AWADDR = '0, ARADDR = '0, WDATA = '0;
  logic        AWVALID = 1'b0, WVALID = 1'b0, ARVALID = 1'b0;
  logic        BREADY = 1'b0, RREADY = 1'b0;
  logic [3:0]  WSTRB = '0, AWCACHE = '0, ARCACHE = '0;
  logic [2:0]  AWPROT = '0, ARPROT = '0;
  logic        AWREADY, WREADY, ARREADY, BVALID, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic        reg_req, reg_wr, reg_ack, reg_err;
  logic [31:0] reg_addr, reg_wdata, reg_rdata;
  logic [3:0]  reg_wstrb;

  axi4l_reg_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .AWCACHE(AWCACHE), .AWPROT(AWPROT),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack), .reg_err(reg_err)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Register-file responder: ack on the (ack_dly+1)-th reg_req cycle,
  // ack_dly >= 8 means it never acks within the timeout window.
  int          ack_dly = 0;
  bit          err_mode = 1'b0;
  int          req_cyc, last_len;
  logic [31:0] mem [0:63];
  bit          acc_wr[$];
  logic [31:0] acc_addr[$];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  assign reg_ack   = reg_req && (req_cyc == ack_dly);
  assign reg_err   = err_mode;
  assign reg_rdata = mem[reg_addr[7:2]];

  initial for (int i = 0; i < 64; i++) mem[i] = '0;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) req_cyc <= 0;
    else if (reg_req) begin
      req_cyc  <= req_cyc + 1;
      last_len <= req_cyc + 1;
      if (reg_ack) begin
        acc_wr.push_back(reg_wr);
        acc_addr.push_back(reg_addr);
        if (reg_wr && !reg_err)
          mem[reg_addr[7:2]] <= merge(mem[reg_addr[7:2]], reg_wdata, reg_wstrb);
      end
    end else req_cyc <= 0;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tmo_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out", nm);
  endtask

  task automatic do_aw(input logic [31:0] a);
    int n = 0;
    AWADDR = a; AWVALID = 1'b1;
    while (!AWREADY && n < 100) begin @(negedge ACLK); n++; end
    if (!AWREADY) tmo_fail("aw_handshake"); else @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    while (!WREADY && n < 100) begin @(negedge ACLK); n++; end
    if (!WREADY) tmo_fail("w_handshake"); else @(negedge ACLK);
    WVALID = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] a);
    int n = 0;
    ARADDR = a; ARVALID = 1'b1;
    while (!ARREADY && n < 100) begin @(negedge ACLK); n++; end
    if (!ARREADY) tmo_fail("ar_handshake"); else @(negedge ACLK);
    ARVALID = 1'b0;
  endtask

  // Wait for B, hold BREADY low bdly cycles checking stability, then accept.
  task automatic wait_b(input int bdly, output logic [1:0] resp);
    int n = 0;
    while (!BVALID && n < 100) begin @(negedge ACLK); n++; end
    if (!BVALID) begin tmo_fail("bvalid_wait"); resp = 2'b11; end
    else begin
      resp = BRESP;
      repeat (bdly) begin
        @(negedge ACLK);
        chk("b_hold", {BVALID, BRESP}, {1'b1, resp});
      end
      BREADY = 1'b1;
      @(negedge ACLK);
      BREADY = 1'b0;
      chk("bvalid_fall", BVALID, 0);
    end
  endtask

  task automatic wait_r(input int rdly, output logic [1:0] resp, output logic [31:0] data);
    int n = 0;
    while (!RVALID && n < 100) begin @(negedge ACLK); n++; end
    if (!RVALID) begin tmo_fail("rvalid_wait"); resp = 2'b11; data = 'x; end
    else begin
      resp = RRESP; data = RDATA;
      repeat (rdly) begin
        @(negedge ACLK);
        chk("r_hold", {RVALID, RRESP, RDATA}, {1'b1, resp, data});
      end
      RREADY = 1'b1;
      @(negedge ACLK);
      RREADY = 1'b0;
      chk("rvalid_fall", RVALID, 0);
    end
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int bdly, output logic [1:0] resp);
    fork
      do_aw(a);
      do_w(d, s);
    join
    wait_b(bdly, resp);
  endtask

  task automatic read_txn(input logic [31:0] a, input int rdly,
                          output logic [1:0] resp, output logic [31:0] data);
    do_ar(a);
    wait_r(rdly, resp, data);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          dly;
    bit          err;
    logic [1:0]  eresp;
    logic [31:0] edata;
    int          elen;
  } vec_t;

  vec_t        tbl[12];
  logic [31:0] ref_mem [0:7];

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int          n, n0;

    // Directed vectors; 0x10 already holds DEADBEEF from the latency test.
    tbl[0]  = '{1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 0,   1'b0, 2'b00, 32'h0,        1};
    tbl[1]  = '{1'b0, 32'h14, 32'h0,        4'h0, 0,   1'b0, 2'b00, 32'hDEADBEEF, 1};
    tbl[2]  = '{1'b1, 32'h14, 32'h12345678, 4'h3, 2,   1'b0, 2'b00, 32'h0,        3};
    tbl[3]  = '{1'b0, 32'h14, 32'h0,        4'h0, 1,   1'b0, 2'b00, 32'hDEAD5678, 2};
    tbl[4]  = '{1'b1, 32'h14, 32'hCAFEF00D, 4'hC, 7,   1'b0, 2'b00, 32'h0,        8};
    tbl[5]  = '{1'b0, 32'h14, 32'h0,        4'h0, 7,   1'b0, 2'b00, 32'hCAFE5678, 8};
    tbl[6]  = '{1'b1, 32'h14, 32'h11111111, 4'hF, 100, 1'b0, 2'b10, 32'h0,        8};
    tbl[7]  = '{1'b0, 32'h14, 32'h0,        4'h0, 100, 1'b0, 2'b10, 32'h0,        8};
    tbl[8]  = '{1'b1, 32'h14, 32'h22222222, 4'hF, 0,   1'b1, 2'b10, 32'h0,        1};
    tbl[9]  = '{1'b0, 32'h14, 32'h0,        4'h0, 3,   1'b1, 2'b10, 32'h0,        4};
    tbl[10] = '{1'b0, 32'h14, 32'h0,        4'h0, 0,   1'b0, 2'b00, 32'hCAFE5678, 1};
    tbl[11] = '{1'b0, 32'h10, 32'h0,        4'h0, 0,   1'b0, 2'b00, 32'hDEADBEEF, 1};
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;

    // Reset state.
    repeat (2) @(negedge ACLK);
    chk("rst_ready", {AWREADY, WREADY, ARREADY}, 0);
    chk("rst_valid", {BVALID, RVALID, reg_req, reg_wr}, 0);
    chk("rst_resp", {BRESP, RRESP}, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wpay", {reg_wdata, reg_wstrb}, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("ready_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Arbitration: W1+R1 tie (write first), then W2 arrives during W1's
    // response so R1 vs W2 tie goes to the read.
    BREADY = 1'b1; RREADY = 1'b1;
    fork
      do_aw(32'h30);
      do_w(32'h1, 4'hF);
      do_ar(32'h34);
    join
    n = 0;
    while (!(AWREADY && WREADY) && n < 50) begin @(negedge ACLK); n++; end
    fork
      do_aw(32'h38);
      do_w(32'h2, 4'hF);
    join
    repeat (12) @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    chk("arb_count", acc_addr.size(), 3);
    if (acc_addr.size() >= 3) begin
      chk("arb_first", {acc_wr[0], acc_addr[0]}, {1'b1, 32'h30});
      chk("arb_second", {acc_wr[1], acc_addr[1]}, {1'b0, 32'h34});
      chk("arb_third", {acc_wr[2], acc_addr[2]}, {1'b1, 32'h38});
    end

    // Write latency with AW and W in the same cycle and immediate ack.
    AWADDR = 32'h10; AWVALID = 1'b1;
    WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    chk("lat_ready", {AWREADY, WREADY}, 2'b11);
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("lat_c1_req", reg_req, 0);
    chk("lat_c1_awready", AWREADY, 0);
    @(negedge ACLK);
    chk("lat_c2_req", {reg_req, reg_wr}, 2'b11);
    chk("lat_c2_addr", reg_addr, 32'h10);
    chk("lat_c2_wdata", {reg_wdata, reg_wstrb}, {32'hDEADBEEF, 4'hF});
    @(negedge ACLK);
    chk("lat_c3_b", {BVALID, BRESP}, 3'b100);
    chk("lat_c3_awready", AWREADY, 1);
    @(negedge ACLK);
    chk("lat_c4_bvalid", BVALID, 0);
    BREADY = 1'b0;

    // AW four cycles ahead of W.
    n0 = acc_addr.size();
    do_aw(32'h20);
    repeat (4) begin
      chk("awearly_awready", AWREADY, 0);
      chk("awearly_noreq", reg_req, 0);
      @(negedge ACLK);
    end
    do_w(32'h0BADF00D, 4'hF);
    wait_b(0, resp);
    chk("awearly_resp", resp, 2'b00);
    chk("awearly_count", acc_addr.size() - n0, 1);
    chk("awearly_addr", {acc_wr[$], acc_addr[$]}, {1'b1, 32'h20});
    chk("awearly_mem", mem[8], 32'h0BADF00D);

    // Vector table.
    foreach (tbl[i]) begin
      ack_dly = tbl[i].dly; err_mode = tbl[i].err;
      if (tbl[i].wr) begin
        write_txn(tbl[i].addr, tbl[i].data, tbl[i].strb, i % 3, resp);
        chk($sformatf("vec%0d_bresp", i), resp, tbl[i].eresp);
      end else begin
        read_txn(tbl[i].addr, i % 3, resp, data);
        chk($sformatf("vec%0d_rresp", i), resp, tbl[i].eresp);
        chk($sformatf("vec%0d_rdata", i), data, tbl[i].edata);
      end
      chk($sformatf("vec%0d_reqlen", i), last_len, tbl[i].elen);
    end
    ack_dly = 0; err_mode = 1'b0;

    // Error write with BREADY held off; a read slips into the AR slot but
    // waits for the B handshake.
    err_mode = 1'b1;
    fork
      do_aw(32'h24);
      do_w(32'h77, 4'hF);
    join
    n = 0;
    while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
    if (!BVALID) tmo_fail("err_bvalid");
    err_mode = 1'b0;
    ARADDR = 32'h10; ARVALID = 1'b1;
    chk("err_arready", ARREADY, 1);
    repeat (5) begin
      @(negedge ACLK);
      ARVALID = 1'b0;
      chk("err_b_hold", {BVALID, BRESP}, 3'b110);
      chk("err_noreq", reg_req, 0);
      chk("err_ar_captured", ARREADY, 0);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    wait_r(0, resp, data);
    chk("err_followup_read", {resp, data}, {2'b00, 32'hDEADBEEF});
    chk("err_mem_untouched", mem[9], 0);

    // Reset in the middle of an access that never gets acked.
    ack_dly = 100;
    fork
      do_aw(32'h60);
      do_w(32'h12121212, 4'hF);
    join
    n = 0;
    while (!reg_req && n < 50) begin @(negedge ACLK); n++; end
    chk("midrst_req_before", reg_req, 1);
    ARESET = 1'b1;
    #1;
    chk("midrst_req", {reg_req, BVALID, RVALID}, 0);
    chk("midrst_ready", {AWREADY, WREADY, ARREADY}, 0);
    @(negedge ACLK);
    ARESET = 1'b0; ack_dly = 0;
    @(negedge ACLK);
    write_txn(32'h60, 32'h34343434, 4'hF, 1, resp);
    chk("midrst_write", resp, 2'b00);
    read_txn(32'h60, 0, resp, data);
    chk("midrst_read", {resp, data}, {2'b00, 32'h34343434});

    // Random traffic against the word-level model at 0x40..0x5C.
    for (int t = 0; t < 40; t++) begin
      bit          wr, er, ok;
      int          word, dly, rdy;
      logic [31:0] d;
      logic [3:0]  s;
      wr = 1'($urandom % 2); word = int'($urandom % 8); dly = int'($urandom % 11);
      er = (($urandom % 8) == 0); d = $urandom; s = 4'($urandom % 16);
      rdy = int'($urandom % 3);
      ok = (dly < 8) && !er;
      ack_dly = dly; err_mode = er;
      if (wr) begin
        write_txn(32'h40 + 32'(word * 4), d, s, rdy, resp);
        chk($sformatf("rnd%0d_bresp", t), resp, ok ? 2'b00 : 2'b10);
        if (ok) ref_mem[word] = merge(ref_mem[word], d, s);
      end else begin
        read_txn(32'h40 + 32'(word * 4), rdy, resp, data);
        chk($sformatf("rnd%0d_rresp", t), resp, ok ? 2'b00 : 2'b10);
        chk($sformatf("rnd%0d_rdata", t), data, ok ? ref_mem[word] : 32'h0);
      end
      chk($sformatf("rnd%0d_reqlen", t), last_len, (dly < 8) ? dly + 1 : 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
